// File: rtl/raycaster_pkg.sv
// Shared raycaster constants, framebuffer state encoding and a saturating-increment helper.
package raycaster_pkg;

  localparam int NUM_COLS      = 640;
  localparam int IDX_W         = 10;
  localparam int HEIGHT_W      = 9;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } fb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/column_height_framebuffer_if.sv
// Producer/consumer bus of the column height framebuffer; master drives requests, slave is the buffer.
interface column_height_framebuffer_if;
  import raycaster_pkg::*;

  logic                wr_valid;
  logic [IDX_W-1:0]    wr_index;
  logic [HEIGHT_W-1:0] wr_height;
  logic                frame_end;
  logic                rd_en;
  logic [IDX_W-1:0]    rd_index;
  logic [HEIGHT_W-1:0] rd_height;
  logic                data_initialised;
  logic                write_new_frame;
  logic                filling;
  logic                err_oob;
  logic [CNT_W-1:0]    late_frames;
  logic [CNT_W-1:0]    dropped_writes;

  modport master (
    output wr_valid, wr_index, wr_height, frame_end, rd_en, rd_index,
    input  rd_height, data_initialised, write_new_frame, filling, err_oob,
           late_frames, dropped_writes
  );

  modport slave (
    input  wr_valid, wr_index, wr_height, frame_end, rd_en, rd_index,
    output rd_height, data_initialised, write_new_frame, filling, err_oob,
           late_frames, dropped_writes
  );

endinterface

// File: rtl/column_height_framebuffer_bank.sv
// One column height bank: single write port plus registered read port, shaped for block RAM inference.
module column_height_bank #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Contents are deliberately never reset so the array maps onto a RAM primitive.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/column_height_framebuffer.sv
// Ping-pong column height store: writes fill the back bank, reads come from the front bank, swaps at frame end.
// Optional FRAME_STATS_EN macro enables the late_frames / dropped_writes counters.
module column_height_framebuffer
  import raycaster_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  column_height_framebuffer_if.slave    bus
);

  localparam logic [IDX_W-1:0] COLS_LIM = IDX_W'(NUM_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLS - 1);

  fb_state_t state_q, state_d;
  logic      front_sel_q, front_sel_d;
  logic      data_init_q, data_init_d;
  logic      wnf_q, wnf_d;
  logic      init_req_q, init_req_d;
  logic      err_oob_q, err_oob_d;
  logic      rd_sel_q, rd_sel_d;
  logic      rd_zero_q, rd_zero_d;

  logic wr_in_range, rd_in_range, wr_ok, complete;
  logic [HEIGHT_W-1:0] bank_rd [2];

  assign wr_in_range = (bus.wr_index < COLS_LIM);
  assign rd_in_range = (bus.rd_index < COLS_LIM);
  assign wr_ok       = bus.wr_valid && wr_in_range && (state_q != S_FULL);
  assign complete    = wr_ok && (bus.wr_index == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    data_init_d = data_init_q;
    wnf_d       = init_req_q;
    init_req_d  = 1'b0;
    err_oob_d   = err_oob_q | (bus.wr_valid & ~wr_in_range);
    rd_sel_d    = rd_sel_q;
    rd_zero_d   = rd_zero_q;

    unique case (state_q)
      S_INIT: begin
        if (complete) begin
          front_sel_d = ~front_sel_q;
          data_init_d = 1'b1;
          state_d     = S_FILL;
          wnf_d       = 1'b1;
        end
      end
      S_FILL: begin
        // A completing write coinciding with frame_end swaps straight away and requests the next frame.
        if (complete && bus.frame_end) begin
          front_sel_d = ~front_sel_q;
          state_d     = S_FILL;
          wnf_d       = 1'b1;
        end else if (complete) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (bus.frame_end) begin
          front_sel_d = ~front_sel_q;
          state_d     = S_FILL;
          wnf_d       = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Bank choice and zero-forcing are captured with the read so a swap-cycle read sees the old bank.
    if (bus.rd_en) begin
      rd_sel_d  = front_sel_q;
      rd_zero_d = ~rd_in_range | ~data_init_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_INIT;
      front_sel_q <= 1'b0;
      data_init_q <= 1'b0;
      wnf_q       <= 1'b0;
      init_req_q  <= 1'b1;
      err_oob_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_zero_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      data_init_q <= data_init_d;
      wnf_q       <= wnf_d;
      init_req_q  <= init_req_d;
      err_oob_q   <= err_oob_d;
      rd_sel_q    <= rd_sel_d;
      rd_zero_q   <= rd_zero_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = 1'(gi);
    column_height_bank #(
      .DEPTH  (NUM_COLS),
      .ADDR_W (IDX_W),
      .DATA_W (HEIGHT_W)
    ) u_bank (
      .clk     (clk),
      .we      (wr_ok && (front_sel_q != BANK_ID)),
      .wr_addr (bus.wr_index),
      .wr_data (bus.wr_height),
      .re      (bus.rd_en && rd_in_range),
      .rd_addr (bus.rd_index),
      .rd_data (bank_rd[gi])
    );
  end

  assign bus.rd_height        = rd_zero_q ? '0 : bank_rd[rd_sel_q];
  assign bus.data_initialised = data_init_q;
  assign bus.write_new_frame  = wnf_q;
  assign bus.filling          = (state_q != S_FULL);
  assign bus.err_oob          = err_oob_q;

`ifdef FRAME_STATS_EN
  logic [CNT_W-1:0] late_q, late_d;
  logic [CNT_W-1:0] dropped_q, dropped_d;

  always_comb begin
    late_d    = late_q;
    dropped_d = dropped_q;
    if ((state_q == S_FILL) && bus.frame_end && !complete) late_d = sat_inc(late_q);
    if ((state_q == S_FULL) && bus.wr_valid) dropped_d = sat_inc(dropped_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      late_q    <= '0;
      dropped_q <= '0;
    end else begin
      late_q    <= late_d;
      dropped_q <= dropped_d;
    end
  end

  assign bus.late_frames    = late_q;
  assign bus.dropped_writes = dropped_q;
`else
  assign bus.late_frames    = '0;
  assign bus.dropped_writes = '0;
`endif

endmodule

// File: tb/tb_column_height_framebuffer.sv
// Directed bench for column_height_framebuffer: read-vector table plus hand-written swap/late/reset sequences.
module tb_column_height_framebuffer;
  import raycaster_pkg::*;

`ifdef FRAME_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  column_height_framebuffer_if fb_if ();

  column_height_framebuffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fb_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int exp;
  } rd_vec_t;

  rd_vec_t vec [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic fill(input int lo, input int hi, input int h, input bit mod_h);
    for (int i = lo; i <= hi; i++) begin
      fb_if.wr_valid  = 1'b1;
      fb_if.wr_index  = IDX_W'(i);
      fb_if.wr_height = mod_h ? HEIGHT_W'(i % 512) : HEIGHT_W'(h);
      tick();
    end
    fb_if.wr_valid = 1'b0;
  endtask

  task automatic rd(input int idx);
    fb_if.rd_en    = 1'b1;
    fb_if.rd_index = IDX_W'(idx);
    tick();
    fb_if.rd_en    = 1'b0;
  endtask

  initial begin
    vec[0] = '{idx: 100,  exp: 100};
    vec[1] = '{idx: 0,    exp: 0};
    vec[2] = '{idx: 5,    exp: 5};
    vec[3] = '{idx: 511,  exp: 511};
    vec[4] = '{idx: 512,  exp: 0};
    vec[5] = '{idx: 639,  exp: 127};
    vec[6] = '{idx: 640,  exp: 0};
    vec[7] = '{idx: 1023, exp: 0};

    fb_if.wr_valid  = 1'b0;
    fb_if.wr_index  = '0;
    fb_if.wr_height = '0;
    fb_if.frame_end = 1'b0;
    fb_if.rd_en     = 1'b0;
    fb_if.rd_index  = '0;

    repeat (3) tick();
    chk("reset wnf", int'(fb_if.write_new_frame), 0);
    chk("reset data_init", int'(fb_if.data_initialised), 0);
    chk("reset rd_height", int'(fb_if.rd_height), 0);
    chk("reset filling", int'(fb_if.filling), 1);
    chk("reset err_oob", int'(fb_if.err_oob), 0);

    // Release: exactly one request pulse, reads forced to zero
    reset = 1'b1;
    tick();
    chk("release wnf pulse", int'(fb_if.write_new_frame), 1);
    tick();
    chk("release wnf once", int'(fb_if.write_new_frame), 0);
    chk("release data_init", int'(fb_if.data_initialised), 0);
    rd(5);
    chk("uninit read 5", int'(fb_if.rd_height), 0);

    // First fill h = i % 512; completing write swaps at once
    fill(0, 639, 0, 1'b1);
    chk("first fill data_init", int'(fb_if.data_initialised), 1);
    chk("first fill wnf", int'(fb_if.write_new_frame), 1);
    tick();
    chk("first fill wnf drop", int'(fb_if.write_new_frame), 0);

    for (int v = 0; v < 8; v++) begin
      rd(vec[v].idx);
      chk($sformatf("table read %0d", vec[v].idx), int'(fb_if.rd_height), vec[v].exp);
    end
    rd(100);
    fb_if.rd_index = 10'd7;
    tick();
    chk("read hold rd_en=0", int'(fb_if.rd_height), 100);

    // Tear-free: back bank filled with 200, front unchanged until frame_end
    fill(0, 639, 200, 1'b0);
    chk("full filling", int'(fb_if.filling), 0);
    chk("full no wnf", int'(fb_if.write_new_frame), 0);
    rd(100);
    chk("pre-swap read 100", int'(fb_if.rd_height), 100);
    fb_if.wr_valid = 1'b1; fb_if.wr_index = 10'd5; fb_if.wr_height = 9'd77;
    tick();
    fb_if.wr_valid = 1'b0;
    chk("dropped_writes", int'(fb_if.dropped_writes), STATS);
    fb_if.frame_end = 1'b1;
    rd(100);
    fb_if.frame_end = 1'b0;
    chk("swap-cycle read old", int'(fb_if.rd_height), 100);
    chk("swap wnf", int'(fb_if.write_new_frame), 1);
    chk("swap filling", int'(fb_if.filling), 1);
    rd(100);
    chk("post-swap read 100", int'(fb_if.rd_height), 200);
    chk("post-swap wnf drop", int'(fb_if.write_new_frame), 0);
    rd(5);
    chk("dropped write absent", int'(fb_if.rd_height), 200);

    // Out-of-range write
    fb_if.wr_valid = 1'b1; fb_if.wr_index = 10'd700; fb_if.wr_height = 9'd55;
    tick();
    fb_if.wr_valid = 1'b0;
    chk("err_oob set", int'(fb_if.err_oob), 1);
    chk("oob still filling", int'(fb_if.filling), 1);
    tick();
    chk("err_oob sticky", int'(fb_if.err_oob), 1);

    // Late frame: back bank holds 0..300 only
    fill(0, 300, 300, 1'b0);
    fb_if.frame_end = 1'b1;
    tick();
    fb_if.frame_end = 1'b0;
    chk("late no wnf", int'(fb_if.write_new_frame), 0);
    chk("late_frames", int'(fb_if.late_frames), STATS);
    rd(100);
    chk("late no swap read", int'(fb_if.rd_height), 200);

    // Completing write together with frame_end
    fill(301, 638, 300, 1'b0);
    fb_if.wr_valid = 1'b1; fb_if.wr_index = 10'd639; fb_if.wr_height = 9'd300;
    fb_if.frame_end = 1'b1;
    tick();
    fb_if.wr_valid = 1'b0;
    fb_if.frame_end = 1'b0;
    chk("simul wnf", int'(fb_if.write_new_frame), 1);
    chk("simul filling", int'(fb_if.filling), 1);
    rd(639);
    chk("simul read 639", int'(fb_if.rd_height), 300);
    chk("simul late unchanged", int'(fb_if.late_frames), STATS);
    rd(100);
    chk("simul read 100", int'(fb_if.rd_height), 300);

    // Reset mid-fill
    fill(0, 10, 9, 1'b0);
    reset = 1'b0;
    tick();
    chk("midreset data_init", int'(fb_if.data_initialised), 0);
    chk("midreset rd_height", int'(fb_if.rd_height), 0);
    chk("midreset err_oob", int'(fb_if.err_oob), 0);
    chk("midreset late", int'(fb_if.late_frames), 0);
    chk("midreset dropped", int'(fb_if.dropped_writes), 0);
    reset = 1'b1;
    tick();
    chk("midreset wnf pulse", int'(fb_if.write_new_frame), 1);
    fb_if.frame_end = 1'b1;
    tick();
    fb_if.frame_end = 1'b0;
    chk("init frame_end ignored wnf", int'(fb_if.write_new_frame), 0);
    chk("init frame_end late", int'(fb_if.late_frames), 0);
    rd(100);
    chk("midreset read 100", int'(fb_if.rd_height), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_height_framebuffer.md
Name: column_height_framebuffer

Overview:
- Ping-pong store for per-column wall heights. Sits between height_calculator (producer) and the pixel renderer (consumer).
- Height results are written into the back bank. Renderer reads from the front bank.
- Banks swap only at end of the visible frame, and only if the back bank is complete. This gives tear-free display.
- Replaces the single mem_height_buffer and the data_initialised / write_new_frame logic in the top level.

Parameters:
- NUM_COLS, 640, number of screen columns / rays per frame
- IDX_W, 10, column index width
- HEIGHT_W, 9, wall height width

Ports:
- clk  in  1  system clock; the single clock domain for this block
- reset  in  1  synchronous, active-low (0 = reset)
- wr_valid  in  1  one-cycle strobe from height_calculator (height_found)
- wr_index  in  IDX_W  column of the result (ray_index)
- wr_height  in  HEIGHT_W  wall height
- frame_end  in  1  one-cycle pulse at last visible pixel (v_pos==479 && h_pos==639, qualified by pixel enable)
- rd_en  in  1  read strobe (pixel-rate enable)
- rd_index  in  IDX_W  column to read (h_pos)
- rd_height  out  HEIGHT_W  registered read data
- data_initialised  out  1  front bank holds a complete frame
- write_new_frame  out  1  one-cycle request to ray pipeline: start computing a frame
- filling  out  1  back bank accepting writes
- err_oob  out  1  sticky: write with wr_index >= NUM_COLS seen
- late_frames  out  16  frames where frame_end arrived before back bank complete (FRAME_STATS_EN only)
- dropped_writes  out  16  writes discarded while not filling (FRAME_STATS_EN only)

Behaviour:
- Reset (reset==0 at posedge):
  - state=S_INIT, front_sel=0, rd_height=0, data_initialised=0, write_new_frame=0, err_oob=0, counters=0.
  - Bank RAM contents are not reset.
- States:
  - S_INIT: first fill, nothing displayable yet.
  - S_FILL: back bank being written.
  - S_FULL: back bank complete, waiting for frame_end.
- Request pulse: write_new_frame pulses exactly one cycle on the first cycle after reset releases, and on every entry to S_FILL. filling = (state != S_FULL).
- Writes:
  - In S_INIT/S_FILL, wr_valid with wr_index < NUM_COLS writes bank[~front_sel][wr_index].
  - wr_index >= NUM_COLS: write dropped, err_oob set (sticky until reset).
  - wr_valid in S_FULL: dropped; dropped_writes increments.
- Completion: an accepted write with wr_index == NUM_COLS-1 completes the bank. Writes are in ascending order; earlier indices are not checked.
  - S_INIT + complete: swap immediately (front_sel toggles next cycle), data_initialised<=1, go to S_FILL, pulse write_new_frame.
  - S_FILL + complete: go to S_FULL.
- Frame end:
  - S_FULL + frame_end: swap, go to S_FILL, pulse write_new_frame.
  - S_FILL + frame_end (bank incomplete): no swap, late_frames increments (saturating), stay in S_FILL.
  - S_INIT + frame_end: ignored.
- Simultaneous completing write and frame_end in S_FILL: write lands, swap occurs that cycle, go to S_FILL with a new request. No late count.
- Reads:
  - Latency 1: rd_en at cycle N gives rd_height valid at N+1. rd_height holds when rd_en=0.
  - Bank used is front_sel as of cycle N; a read in the swap cycle returns old-bank data.
  - rd_index >= NUM_COLS returns 0.
  - While data_initialised=0, reads return 0.
- data_initialised never deasserts except on reset.
- Reset mid-fill: partial back bank abandoned; restart in S_INIT with a fresh request.
- Width rules: counters 16-bit saturating at 0xFFFF. No arithmetic on heights.

Optional Feature:
- Macro FRAME_STATS_EN.
- Defined: late_frames and dropped_writes implemented as described.
- Undefined: both ports tied to 0, no counter flops. All other behaviour identical.

Decomposition:
- Shared package raycaster_pkg:
  - NUM_COLS, IDX_W, HEIGHT_W, SCREEN_HEIGHT=480.
  - 2-bit fb_state_t enum: S_INIT=0, S_FILL=1, S_FULL=2.
- One sub-module, column_height_bank: NUM_COLS x HEIGHT_W RAM, one write port, registered read port, BRAM-inferable. Instantiated twice.
- Output mux selects read data by registered front_sel.

Test Plan:
- Reset release: write_new_frame pulses once at cycle 1; data_initialised=0; rd_en at index 5 gives rd_height=0.
- First fill: write heights h=i%512 for i=0..639. After the index-639 write: data_initialised=1, second write_new_frame pulse; read index 100 gives 100 one cycle later.
- Tear-free swap: fill back bank with 200 everywhere, no frame_end. Reads still return the old values. After frame_end, reads return 200 and write_new_frame pulses.
- Late frame: frame_end while the back bank holds only indices 0..300 gives no swap; late_frames=1 (with FRAME_STATS_EN), 0 (without).
- Edge cases:
  - wr_index=700 gives err_oob=1 and no RAM change.
  - Write in S_FULL increments dropped_writes.
  - rd_index=640 returns 0.
- Simultaneous index-639 write and frame_end: swap that cycle; a read of 639 on the next cycle returns the new height; late_frames unchanged. Assert reset mid-fill: state returns to S_INIT and data_initialised drops to 0.
